outer_acc_24: RTL and testbench

Backward-path companion to the dense-layer inner-product unit. It takes a stream of (scalar gradient, 24-element vector) pairs and computes the scaled vector `s·v` element-wise. It accumulates that vector over a batch of `BATCH` pairs and hands the accumulated 24-element result downstream with a valid/ready handshake. It sits in the trained dense layer's weight-gradient path, producing one accumulated gradient row per batch, in the same fixed-point format as the forward path.

---
 rtl/outer_acc_24_pkg.sv | 22 ++
 rtl/outer_acc_24_scale_acc_lane.sv | 56 +++++
 rtl/outer_acc_24.sv | 131 +++++++++++++
 tb/tb_outer_acc_24.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/outer_acc_24_pkg.sv
// Shared constants and types for the outer-product gradient accumulator.
package outer_acc_24_pkg;

  // Trained-layer geometry and fixed-point format shared with the forward path.
  localparam int DIM_DEF   = 24;
  localparam int N_LEN_DEF = 16;
  localparam int F_LEN_DEF = 8;
  localparam int BATCH_DEF = 4;

  // ACC: taking inputs; DRAIN: waiting for the last product to land; OUT: presenting q.
  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OUT   = 2'd2
  } acc_state_e;

  // Counter width able to hold the value BATCH itself.
  function automatic int cnt_width(input int batch);
    return (batch < 1) ? 1 : $clog2(batch + 1);
  endfunction

endpackage

// File: rtl/outer_acc_24_scale_acc_lane.sv
// One vector lane: registered full-width product and a wrapping accumulator
// fed by the fixed-point slice of that product (truncation, no rounding).
module scale_acc_lane
  import outer_acc_24_pkg::*;
#(
  parameter int N_LEN = N_LEN_DEF,
  parameter int F_LEN = F_LEN_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic                    acc_en_i,
  input  logic                    zero_i,
  input  logic signed [N_LEN-1:0] s_i,
  input  logic signed [N_LEN-1:0] v_i,
  output logic        [N_LEN-1:0] acc_o
);

  logic signed [2*N_LEN-1:0] mul_q, mul_d;
  logic        [N_LEN-1:0]   acc_q, acc_d;
  logic                      unused_mul;

  // Stage 1: capture the product when an input pair is accepted.
  always_comb begin
    mul_d = mul_q;
    if (load_i) begin
      mul_d = s_i * v_i;
    end
  end

  // Stage 2: add the truncated product; zeroing wins over accumulation.
  always_comb begin
    acc_d = acc_q;
    if (zero_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
      acc_d = acc_q + mul_q[F_LEN +: N_LEN];
    end
  end

  // Lane registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_q <= '0;
      acc_q <= '0;
    end else begin
      mul_q <= mul_d;
      acc_q <= acc_d;
    end
  end

  // Only the fixed-point slice of the product is consumed.
  assign unused_mul = ^mul_q;
  assign acc_o      = acc_q;

endmodule

// File: rtl/outer_acc_24.sv
// Batch accumulator of scaled vectors s*v for the dense-layer weight-gradient path.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_ACC   | accepting input pairs until BATCH of them have been taken
// ST_DRAIN | last product in flight; wait for acc_cnt to reach BATCH
// ST_OUT   | q holds the completed batch, out_valid high until out_ready
module outer_acc_24
  import outer_acc_24_pkg::*;
#(
  parameter int DIM   = DIM_DEF,
  parameter int N_LEN = N_LEN_DEF,
  parameter int F_LEN = F_LEN_DEF,
  parameter int BATCH = BATCH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_LEN-1:0]       s,
  input  logic [DIM*N_LEN-1:0]   v,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DIM*N_LEN-1:0]   q
);

  localparam int               CNT_W   = cnt_width(BATCH);
  localparam logic [CNT_W-1:0] BATCH_C = CNT_W'(BATCH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(BATCH - 1);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  acc_state_e       state_q, state_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             v1_q, v1_d;
  logic             alive_q;
  logic             in_fire;
  logic             out_fire;
  logic             acc_zero;

  // in_ready stays low while reset is held and rises after the first clock out of reset.
  assign in_ready  = alive_q && (state_q == ST_ACC) && (in_cnt_q < BATCH_C) && !clear;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (state_q == ST_OUT);
  assign out_fire  = out_valid && out_ready && !clear;

  // Next-state, counter and pipeline-valid logic; clear overrides everything.
  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    acc_cnt_d = acc_cnt_q;
    v1_d      = 1'b0;
    acc_zero  = 1'b0;
    if (clear) begin
      state_d   = ST_ACC;
      in_cnt_d  = '0;
      acc_cnt_d = '0;
      acc_zero  = 1'b1;
    end else begin
      if (in_fire) begin
        in_cnt_d = in_cnt_q + ONE_C;
        v1_d     = 1'b1;
      end
      if (v1_q) begin
        acc_cnt_d = acc_cnt_q + ONE_C;
      end
      unique case (state_q)
        ST_ACC: begin
          if (in_fire && (in_cnt_q == LAST_C)) begin
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (acc_cnt_q == BATCH_C) begin
            state_d = ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_fire) begin
            state_d   = ST_ACC;
            in_cnt_d  = '0;
            acc_cnt_d = '0;
            acc_zero  = 1'b1;
          end
        end
        default: begin
          state_d   = ST_ACC;
          in_cnt_d  = '0;
          acc_cnt_d = '0;
          acc_zero  = 1'b1;
        end
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ACC;
      in_cnt_q  <= '0;
      acc_cnt_q <= '0;
      v1_q      <= 1'b0;
      alive_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      acc_cnt_q <= acc_cnt_d;
      v1_q      <= v1_d;
      alive_q   <= 1'b1;
    end
  end

  // One multiply/accumulate lane per vector element; q is the lane accumulators.
  for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
    scale_acc_lane #(
      .N_LEN (N_LEN),
      .F_LEN (F_LEN)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load_i   (in_fire),
      .acc_en_i (v1_q),
      .zero_i   (acc_zero),
      .s_i      (s),
      .v_i      (v[gi*N_LEN +: N_LEN]),
      .acc_o    (q[gi*N_LEN +: N_LEN])
    );
  end

endmodule

// File: tb/tb_outer_acc_24.sv
// Scoreboard bench for outer_acc_24: drivers push expected batch results,
// a monitor pops and compares on every output handshake.
module tb_outer_acc_24;

  localparam int DIM = 24;
  localparam int NL  = 16;
  localparam int FL  = 8;
  localparam int B   = 4;
  localparam int VW  = DIM * NL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NL-1:0] s = '0;
  logic [VW-1:0] v = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [VW-1:0] q;

  int n_cmp = 0;
  int n_bad = 0;

  logic [VW-1:0] exp_q[$];
  logic [NL-1:0] part[DIM];
  int            n_part = 0;
  bit            rnd_done = 0;

  outer_acc_24 #(.DIM(DIM), .N_LEN(NL), .F_LEN(FL), .BATCH(B)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .v         (v),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] fill(input logic [NL-1:0] x);
    logic [VW-1:0] r;
    for (int i = 0; i < DIM; i++) r[i*NL +: NL] = x;
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r;
    for (int i = 0; i < DIM; i++) r[i*NL +: NL] = NL'($urandom);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DIM; i++) part[i] = '0;
    n_part = 0;
  endtask

  // Reference: sum over the batch of floor(s*v / 2^F), kept modulo 2^N.
  task automatic model_accept(input logic [NL-1:0] sv, input logic [VW-1:0] vv);
    int a, b, p;
    logic [NL-1:0] el;
    logic [VW-1:0] res;
    a = int'($signed(sv));
    for (int i = 0; i < DIM; i++) begin
      el = vv[i*NL +: NL];
      b = int'($signed(el));
      p = (a * b) >>> FL;
      part[i] = part[i] + NL'(p);
    end
    n_part++;
    if (n_part == B) begin
      for (int i = 0; i < DIM; i++) res[i*NL +: NL] = part[i];
      exp_q.push_back(res);
      model_reset();
    end
  endtask

  // Present one pair; called and returns at 1ns after a rising edge.
  task automatic send(input logic [NL-1:0] sv, input logic [VW-1:0] vv);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    s = sv;
    v = vv;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(sv, vv);
        done = 1;
      end else if (++n > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: in_ready stayed %0b, required 1", in_ready);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; returns at a falling edge.
  task automatic wait_out(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    if (!out_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: out_valid=%0b after %0d cycles, required 1", nm, out_valid, n);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(nm, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every output handshake must match the oldest expectation.
  always @(negedge clk) begin
    logic [VW-1:0] e;
    if (!rst && out_valid && out_ready && !clear) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: output q=%h, required no output", q);
      end else begin
        e = exp_q.pop_front();
        if (q !== e) begin
          n_bad++;
          $display("FAIL sb_q: got %h expected %h", q, e);
        end
      end
    end
  end

  initial begin
    logic [VW-1:0] vv;
    logic [VW-1:0] held_q;
    logic [VW-1:0] junk;
    model_reset();

    // Reset state.
    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_q_zero", (q == '0), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rel_in_ready_low", in_ready, 0);
    @(posedge clk);
    #1;
    check("rst_rel_in_ready_high", in_ready, 1);

    // Basic batch with latency/width timing.
    for (int i = 0; i < DIM; i++) vv[i*NL +: NL] = NL'(i * 256);
    for (int k = 0; k < B; k++) send(16'h0100, vv);
    @(negedge clk);
    check("basic_ov_t0", out_valid, 0);
    @(negedge clk);
    check("basic_ov_t1", out_valid, 0);
    @(negedge clk);
    check("basic_ov_t2", out_valid, 1);
    check("basic_q5", q[5*NL +: NL], 32'h1400);
    check("basic_ir_in_out", in_ready, 0);
    @(negedge clk);
    check("basic_ov_t3", out_valid, 0);
    check("basic_ir_t3", in_ready, 1);
    wait_idle("basic_idle");

    // Signs and fraction.
    for (int k = 0; k < B; k++) send(16'hFF80, fill(16'h0300));
    wait_out("sign_wait");
    check("sign_q0", q[0 +: NL], 32'hFA00);
    check("sign_q23", q[23*NL +: NL], 32'hFA00);
    wait_idle("sign_idle");

    // Wrap-around, no saturation.
    for (int k = 0; k < B; k++) send(16'h7F00, fill(16'h0100));
    wait_out("wrap_wait");
    check("wrap_q7", q[7*NL +: NL], 32'hFC00);
    wait_idle("wrap_idle");

    // Backpressure with in_valid held high.
    out_ready = 1'b0;
    for (int k = 0; k < B; k++) send(16'h0100, fill(16'h0200));
    fork
      send(16'h0100, fill(16'h0100));
      begin
        wait_out("bp_wait");
        held_q = q;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          check("bp_q_stable", (q == held_q), 1);
          check("bp_in_ready", in_ready, 0);
          check("bp_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_in_ready", in_ready, 0);
      end
    join
    for (int k = 1; k < B; k++) send(16'h0100, fill(16'h0100));
    wait_idle("bp_idle");

    // Clear mid-batch.
    send(16'h0100, fill(16'h0100));
    send(16'h0100, fill(16'h0100));
    clear = 1'b1;
    model_reset();
    @(negedge clk);
    check("clr_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    for (int k = 0; k < B; k++) send(16'h0100, fill(16'h0100));
    wait_out("clr_wait");
    check("clr_q0", q[0 +: NL], 32'h0400);
    wait_idle("clr_idle");

    // Clear while presenting output.
    out_ready = 1'b0;
    for (int k = 0; k < B; k++) send(16'h0100, fill(16'h0100));
    wait_out("clro_wait");
    @(posedge clk);
    #1;
    clear = 1'b1;
    junk = exp_q.pop_back();
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    check("clro_ov_drop", out_valid, 0);
    check("clro_q_zero", (q == '0), 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset during DRAIN.
    for (int k = 0; k < B; k++) send(16'h0100, fill(16'h0100));
    #2;
    rst = 1'b1;
    #1;
    check("rstd_out_valid", out_valid, 0);
    check("rstd_in_ready", in_ready, 0);
    check("rstd_q_zero", (q == '0), 1);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rstd_rel_in_ready", in_ready, 1);
    for (int k = 0; k < B; k++) send(NL'($urandom), rand_vec());
    wait_idle("rstd_idle");

    // Randomized batches with random gaps and random backpressure.
    rnd_done = 0;
    fork
      begin
        for (int k = 0; k < 15 * B; k++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(NL'($urandom), rand_vec());
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_idle("rand_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
